// File: rtl/br_port_arbiter.sv
// br_port_arbiter
//   Shares the single register-bank port set between requester A (CPU
//   datapath) and requester B (loader/debug). Round-robin arbitration with
//   an optional bounded lock, valid/ready handshake per side, and a
//   registered read response one cycle after acceptance.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   a_* / b_*               requester A / B: valid, ready, lock, we,
//                           ra1, ra2, wa, wd in; rsp_valid, dr1, dr2 out
//   RA1, RA2, WA, Din       bank addresses / write data (muxed from grantee)
//   RegWrite                bank write enable
//   DR1, DR2                bank combinational read data
//
// Build option
//   BR_R0_PROTECT_EN  when defined, register 0 reads as zero and writes to
//                     it are accepted but never reach the bank.
module br_port_arbiter #(
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic          a_lock,
  input  logic          a_we,
  input  logic [AW-1:0] a_ra1,
  input  logic [AW-1:0] a_ra2,
  input  logic [AW-1:0] a_wa,
  input  logic [DW-1:0] a_wd,
  output logic          a_rsp_valid,
  output logic [DW-1:0] a_dr1,
  output logic [DW-1:0] a_dr2,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic          b_lock,
  input  logic          b_we,
  input  logic [AW-1:0] b_ra1,
  input  logic [AW-1:0] b_ra2,
  input  logic [AW-1:0] b_wa,
  input  logic [DW-1:0] b_wd,
  output logic          b_rsp_valid,
  output logic [DW-1:0] b_dr1,
  output logic [DW-1:0] b_dr2,
  output logic [AW-1:0] RA1,
  output logic [AW-1:0] RA2,
  output logic [AW-1:0] WA,
  output logic [DW-1:0] Din,
  output logic          RegWrite,
  input  logic [DW-1:0] DR1,
  input  logic [DW-1:0] DR2
);

  localparam int unsigned CW = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  state_t        state;
  logic          last_b;     // 1: last grant went to B
  logic [CW-1:0] lock_cnt;
  logic [CW-1:0] lock_cnt_nxt;
  logic          grant_a, grant_b;
  logic          acc_a, acc_b;
  logic          we_raw;
  logic [DW-1:0] rd1, rd2;

  // lock_cnt counts consecutive grants to the current owner while the other
  // side is waiting; a fresh round-robin grant to a locking side counts as
  // the first of those, so the owner gets MAX_LOCK grants in a row in total.
  always_comb begin
    grant_a      = 1'b0;
    grant_b      = 1'b0;
    lock_cnt_nxt = '0;
    if (a_valid && !b_valid) begin
      grant_a = 1'b1;
    end else if (b_valid && !a_valid) begin
      grant_b = 1'b1;
    end else if (a_valid && b_valid) begin
      if (state == OWN_A && a_lock && lock_cnt < CW'(MAX_LOCK)) begin
        grant_a      = 1'b1;
        lock_cnt_nxt = lock_cnt + CW'(1);
      end else if (state == OWN_B && b_lock && lock_cnt < CW'(MAX_LOCK)) begin
        grant_b      = 1'b1;
        lock_cnt_nxt = lock_cnt + CW'(1);
      end else begin
        grant_a      = last_b;
        grant_b      = !last_b;
        lock_cnt_nxt = (last_b ? a_lock : b_lock) ? CW'(1) : '0;
      end
    end
  end

  // Gating with rst_n keeps the bank untouched while reset is held.
  assign acc_a   = grant_a & rst_n;
  assign acc_b   = grant_b & rst_n;
  assign a_ready = acc_a;
  assign b_ready = acc_b;

  always_comb begin
    RA1    = '0;
    RA2    = '0;
    WA     = '0;
    Din    = '0;
    we_raw = 1'b0;
    if (acc_a) begin
      RA1    = a_ra1;
      RA2    = a_ra2;
      WA     = a_wa;
      Din    = a_wd;
      we_raw = a_we;
    end else if (acc_b) begin
      RA1    = b_ra1;
      RA2    = b_ra2;
      WA     = b_wa;
      Din    = b_wd;
      we_raw = b_we;
    end
  end

`ifdef BR_R0_PROTECT_EN
  assign RegWrite = we_raw & (WA != '0);
  assign rd1      = (RA1 == '0) ? '0 : DR1;
  assign rd2      = (RA2 == '0) ? '0 : DR2;
`else
  assign RegWrite = we_raw;
  assign rd1      = DR1;
  assign rd2      = DR2;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_b      <= 1'b1;
      lock_cnt    <= '0;
      a_rsp_valid <= 1'b0;
      b_rsp_valid <= 1'b0;
      a_dr1       <= '0;
      a_dr2       <= '0;
      b_dr1       <= '0;
      b_dr2       <= '0;
    end else begin
      lock_cnt <= lock_cnt_nxt;
      if (grant_a) begin
        state  <= OWN_A;
        last_b <= 1'b0;
      end else if (grant_b) begin
        state  <= OWN_B;
        last_b <= 1'b1;
      end else begin
        state  <= IDLE;
      end
      // Captured before the bank write lands, so this is pre-write data.
      a_rsp_valid <= acc_a;
      b_rsp_valid <= acc_b;
      if (acc_a) begin
        a_dr1 <= rd1;
        a_dr2 <= rd2;
      end
      if (acc_b) begin
        b_dr1 <= rd1;
        b_dr2 <= rd2;
      end
    end
  end

endmodule
